// File: rtl/regfile_param.sv
// regfile_param: DEPTH x DATA_W register file, one write port, two
// registered write-first read ports, optional zero R0, bulk-clear engine.
// Ports: clk, rst (sync, active high); ra/rb read addrs; rd/wd/we write;
//   clr_req starts a clear; ra_out/rb_out read data; busy, clr_done status.
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic              clr_req,
  output logic [DATA_W-1:0] ra_out,
  output logic [DATA_W-1:0] rb_out,
  output logic              busy,
  output logic              clr_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok, clr_wr, done_nx;
  logic [DATA_W-1:0] ra_nx, rb_nx;

  assign wr_ok = we && !busy
              && !(ZERO_R0 && rd == '0);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    clr_wr   = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          idx_nx   = '0;
        end
      end
      CLEAR: begin
        clr_wr = 1'b1;
        idx_nx = idx + 1'b1;
        if (idx == LAST) begin
          state_nx = IDLE;
          idx_nx   = '0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read value as seen after this edge's write
  // (clear zeroing or accepted write).
  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] a
  );
    if (ZERO_R0 && a == '0)
      return '0;
    else if (clr_wr && a == idx)
      return '0;
    else if (wr_ok && a == rd)
      return wd;
    else
      return mem[a];
  endfunction

  always_comb begin
    ra_nx = rd_val(ra);
    rb_nx = rd_val(rb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      ra_out   <= '0;
      rb_out   <= '0;
    end else begin
      if (clr_wr)
        mem[idx] <= '0;
      if (wr_ok)
        mem[rd] <= wd;
      state    <= state_nx;
      idx      <= idx_nx;
      busy     <= (state_nx == CLEAR);
      clr_done <= done_nx;
      ra_out   <= ra_nx;
      rb_out   <= rb_nx;
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: self-checking bench for regfile_param.
// Read expectations are queued at drive time and popped after the edge.
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst, we, clr_req;
  logic [3:0]  ra, rb, rd;
  logic [15:0] wd;
  logic [15:0] ra_out, rb_out, z_ra_out, z_rb_out;
  logic        busy, clr_done, z_busy, z_clr_done;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb),
    .rd(rd), .wd(wd), .we(we), .clr_req(clr_req),
    .ra_out(ra_out), .rb_out(rb_out),
    .busy(busy), .clr_done(clr_done)
  );

  regfile_param #(.ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb),
    .rd(rd), .wd(wd), .we(we), .clr_req(clr_req),
    .ra_out(z_ra_out), .rb_out(z_rb_out),
    .busy(z_busy), .clr_done(z_clr_done)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [15:0] mdl [16];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] base);
    we = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rd = 4'(k);
      wd = base + 16'(k);
      mdl[k] = wd;
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; clr_req = 1'b0;
    ra = '0; rb = '0; rd = '0; wd = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if (ra_out !== 16'h0 || rb_out !== 16'h0
        || busy !== 1'b0 || clr_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: ra=%h rb=%h busy=%b done=%b want 0",
               ra_out, rb_out, busy, clr_done);
    end
    for (int k = 0; k < 16; k++) begin
      mdl[k] = '0;
      ra = 4'(k); rb = 4'(15 - k);
      q.push_back('{16'h0, 16'h0});
      tick();
      e = q.pop_front();
      n_cmp++;
      if (ra_out !== e.a || rb_out !== e.b) begin
        n_bad++;
        $display("FAIL reset_reg%0d: got %h/%h want %h/%h",
                 k, ra_out, rb_out, e.a, e.b);
      end
    end
  endtask

  task automatic test_bypass();
    rd = 4'd3; wd = 16'hBEEF; we = 1'b1;
    ra = 4'd3; rb = 4'd0;
    mdl[3] = 16'hBEEF;
    q.push_back('{16'hBEEF, mdl[0]});
    tick();
    e = q.pop_front();
    n_cmp++;
    if (ra_out !== e.a || rb_out !== e.b) begin
      n_bad++;
      $display("FAIL bypass: got %h/%h want %h/%h",
               ra_out, rb_out, e.a, e.b);
    end
    we = 1'b0;
    q.push_back('{mdl[3], mdl[0]});
    tick();
    e = q.pop_front();
    n_cmp++;
    if (ra_out !== e.a) begin
      n_bad++;
      $display("FAIL bypass_hold: got %h want %h", ra_out, e.a);
    end
  endtask

  task automatic test_same_reg();
    rd = 4'd5; wd = 16'h5555; we = 1'b1;
    tick();
    mdl[5] = 16'h1234;
    ra = 4'd5; rb = 4'd5; wd = 16'h1234;
    q.push_back('{16'h1234, 16'h1234});
    tick();
    we = 1'b0;
    e = q.pop_front();
    n_cmp++;
    if (ra_out !== e.a || rb_out !== e.b) begin
      n_bad++;
      $display("FAIL same_reg: got %h/%h want %h/%h",
               ra_out, rb_out, e.a, e.b);
    end
  endtask

  task automatic test_zero_r0();
    rd = 4'd0; wd = 16'hFFFF; we = 1'b1;
    ra = 4'd7; rb = 4'd7;
    mdl[0] = 16'hFFFF;
    tick();
    we = 1'b0; ra = 4'd0; rb = 4'd0;
    q.push_back('{16'hFFFF, 16'h0000});
    tick();
    e = q.pop_front();
    n_cmp++;
    if (ra_out !== e.a || z_ra_out !== e.b
        || z_rb_out !== e.b) begin
      n_bad++;
      $display("FAIL zero_r0: plain=%h zero=%h/%h want %h/%h",
               ra_out, z_ra_out, z_rb_out, e.a, e.b);
    end
  endtask

  task automatic test_clear();
    fill(16'h0001);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_start: busy=%b want 1", busy);
    end
    for (int i = 1; i <= 16; i++) begin
      we = 1'b1; rd = 4'((i + 7) % 16); wd = 16'hDEAD;
      tick();
      n_cmp++;
      if (busy !== (i < 16) || clr_done !== (i == 16)) begin
        n_bad++;
        $display("FAIL clr_cyc%0d: busy=%b done=%b want %b/%b",
                 i, busy, clr_done, i < 16, i == 16);
      end
    end
    for (int k = 0; k < 16; k++)
      mdl[k] = '0;
    rd = 4'd9; wd = 16'hA5A5; we = 1'b1;
    ra = 4'd9; rb = 4'd2;
    mdl[9] = 16'hA5A5;
    q.push_back('{16'hA5A5, 16'h0});
    tick();
    we = 1'b0;
    e = q.pop_front();
    n_cmp++;
    if (ra_out !== e.a || rb_out !== e.b
        || clr_done !== 1'b0) begin
      n_bad++;
      $display("FAIL post_clr_wr: got %h/%h done=%b want %h/%h/0",
               ra_out, rb_out, clr_done, e.a, e.b);
    end
    for (int k = 0; k < 16; k++) begin
      ra = 4'(k); rb = 4'(k);
      q.push_back('{mdl[k], mdl[k]});
      tick();
      e = q.pop_front();
      n_cmp++;
      if (ra_out !== e.a || rb_out !== e.b) begin
        n_bad++;
        $display("FAIL clr_reg%0d: got %h/%h want %h",
                 k, ra_out, rb_out, e.a);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int t;
    fill(16'h0100);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 16; k++)
      mdl[k] = '0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (busy !== 1'b0 || clr_done !== 1'b0
          || ra_out !== 16'h0 || rb_out !== 16'h0) begin
        n_bad++;
        $display("FAIL mid_rst%0d: busy=%b done=%b ra=%h rb=%h want 0",
                 i, busy, clr_done, ra_out, rb_out);
      end
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      ra = 4'(k); rb = 4'(k);
      q.push_back('{16'h0, 16'h0});
      tick();
      e = q.pop_front();
      n_cmp++;
      if (ra_out !== e.a || rb_out !== e.b) begin
        n_bad++;
        $display("FAIL mid_rst_reg%0d: got %h/%h want 0",
                 k, ra_out, rb_out);
      end
    end
    we = 1'b1;
    rd = 4'd0; wd = 16'h0077; tick();
    rd = 4'd1; wd = 16'h0088; tick();
    we = 1'b0;
    clr_req = 1'b1;
    ra = 4'd0; rb = 4'd1;
    tick();
    clr_req = 1'b0;
    q.push_back('{16'h0000, 16'h0088});
    q.push_back('{16'h0000, 16'h0000});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = q.pop_front();
      n_cmp++;
      if (ra_out !== e.a || rb_out !== e.b) begin
        n_bad++;
        $display("FAIL restart%0d: got %h/%h want %h/%h",
                 i, ra_out, rb_out, e.a, e.b);
      end
    end
    t = 0;
    while (busy === 1'b1 && t < 40) begin
      tick();
      t++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_to: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int lo;
    lo = 0;
    clr_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (busy === 1'b0)
        lo++;
      n_cmp++;
      if (busy !== !(c == 17 || c == 34)
          || clr_done !== (c == 17 || c == 34)) begin
        n_bad++;
        $display("FAIL b2b_cyc%0d: busy=%b done=%b want %b/%b",
                 c, busy, clr_done,
                 !(c == 17 || c == 34), c == 17 || c == 34);
      end
    end
    clr_req = 1'b0;
    n_cmp++;
    if (lo !== 2) begin
      n_bad++;
      $display("FAIL b2b_lo: busy low %0d cycles want 2", lo);
    end
    t = 0;
    while (busy === 1'b1 && t < 40) begin
      tick();
      t++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_to: busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_same_reg();
    test_zero_r0();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
